ec_dec_symbol_search: RTL and testbench
=======================================

# ec_dec_symbol_search

Symbol-search stage of the AV1 arithmetic decoder; the receive-side counterpart of the encoder's first stage. It accepts a normalized range and the top 16 bits of the decoder window. It walks the inverse-CDF table one entry per cycle through a synchronous-read CDF port to find the decoded symbol. It returns the symbol, the renormalized range, the subtracted window value and the renormalization shift to the window-refill stage.

## Interface
- RANGE_WIDTH, 16, range/window/CDF datapath width
- SYMBOL_WIDTH, 4, symbol index width
- CDF_ADDR_WIDTH, 4, CDF table address width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid / in_ready  in / out  1 each  request handshake
- RNG  in  16  current range, must be ≥ 32768
- DIF  in  16  top 16 bits of the decoder window (c)
- NSYMS  in  5  number of symbols, 2..16
- BOOL  in  1  boolean decode; forces N = 1
- CDF_ADDR  out  4  inverse-CDF entry index
- CDF_DATA  in  16  icdf[CDF_ADDR presented on the previous cycle], 1-cycle registered read
- out_valid / out_ready  out / in  1 each  result handshake
- SYMBOL_OUT  out  4  decoded symbol
- RNG_OUT  out  16  renormalized range
- DIF_OUT  out  16  c − v, not yet shifted
- D_OUT  out  4  renormalization shift d

## Operation
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid, latch RNG, DIF, and N = BOOL ? 1 : max(NSYMS,2) − 1. Set u = RNG and idx counter k = 0. Go to FETCH.
  - FETCH: CDF_ADDR = 0. Set k = 1. Go to SEARCH.
  - SEARCH: the current entry is idx = k − 1. CDF_ADDR = k, a prefetch; an address beyond N is harmless.
    - v = (((r>>8) × (CDF_DATA>>6)) >> 1) + 4×(N − idx), with r being the latched RNG. Compute in 17 bits.
    - If c < v and idx < N: u ← v, k ← k + 1, stay in SEARCH.
    - Otherwise: stop with symbol s = idx and go to DONE. At idx = N the search is forced to stop regardless of CDF_DATA.
  - DONE: out_valid = 1. Outputs are registered on entry and held stable until out_ready. On the handshake, go to IDLE.
- Result on stop:
  - rs = u − v (16 bits, nonzero for a valid CDF).
  - d = count of leading zeros of rs.
  - RNG_OUT = rs << d.
  - DIF_OUT = c − v.
  - D_OUT = d.
  - SYMBOL_OUT = s.
- Inputs are ignored outside the IDLE accept cycle. Only one request is in flight; requests do not overlap.
- Behaviour for RNG < 32768, or for a non-monotone CDF, is undefined.

## Timing
- Reset values: out_valid 0, SYMBOL_OUT 0, RNG_OUT 0, DIF_OUT 0, D_OUT 0, CDF_ADDR 0, state IDLE.
- in_ready is 0 while reset is high. It is 1 in the cycle after reset deasserts.
- Accept at edge E0:
  - CDF_ADDR = 0 during the cycle after E0.
  - Entry idx is compared in the cycle after edge E0+1+idx.
  - out_valid rises after edge E0+s+2.
  - Minimum latency is 2 (s = 0). Maximum is 17 (s = 15, N = 15).
- Back-to-back operation: the DONE handshake at edge Ex returns the block to IDLE. The next accept can happen at Ex+1, so throughput is s+4 cycles per symbol with no stalls.
- in_ready and out_valid are never high in the same cycle.
- Reset mid-operation (FETCH, SEARCH or DONE):
  - The next edge returns the block to IDLE with all outputs at their reset values.
  - The result in progress is discarded and no partial out_valid is issued.
- Reset dominates a simultaneous in_valid or out_ready.

## Test plan
- Bool, symbol 0:
  - Stimulus: RNG=32768, DIF=20000, BOOL=1, icdf[0]=16384.
  - Required: v=16388, SYMBOL_OUT=0, RNG_OUT=65520, D_OUT=2, DIF_OUT=3612.
  - Required: out_valid after E0+2, CDF_ADDR sequence 0,1.
- Bool, symbol 1:
  - Stimulus: same as above with DIF=100, icdf[1]=0.
  - Required: SYMBOL_OUT=1, RNG_OUT=32776, D_OUT=1, DIF_OUT=100.
  - Required: out_valid after E0+3.
- Multi-symbol:
  - Stimulus: NSYMS=4, RNG=65280, DIF=30000, icdf={24576,16384,8192,0}.
  - Required: v sequence 48972, 32648, 16324.
  - Required: SYMBOL_OUT=2, RNG_OUT=65296, D_OUT=2, DIF_OUT=13676, out_valid after E0+4.
- Backpressure:
  - Stimulus: the multi-symbol case with out_ready held low for 5 cycles.
  - Required: all outputs stable, in_ready=0 throughout.
  - Required: after the handshake, in_ready=1 next cycle, and a second request is accepted back-to-back with the correct result.
- Reset mid-search:
  - Stimulus: assert reset for 1 cycle during SEARCH of NSYMS=16, DIF=0 (worst case, s=15).
  - Required: out_valid never rises, outputs 0, in_ready=1 one cycle after reset drops.
  - Required: the next request decodes correctly.
- Max-length search:
  - Stimulus: NSYMS=16, DIF=0, icdf a uniform 16-entry table ending in 0.
  - Required: SYMBOL_OUT=15, out_valid after E0+17, CDF_ADDR sequence covers 0..15.

Source files
------------

// File: rtl/ec_dec_symbol_search.sv
// rtl/ec_dec_symbol_search.sv - AV1 decoder symbol search over a synchronous-read inverse-CDF table
module ec_dec_symbol_search #(
    parameter int RANGE_WIDTH    = 16,
    parameter int SYMBOL_WIDTH   = 4,
    parameter int CDF_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [RANGE_WIDTH-1:0]    RNG,
    input  logic [RANGE_WIDTH-1:0]    DIF,
    input  logic [SYMBOL_WIDTH:0]     NSYMS,
    input  logic                      BOOL,
    output logic [CDF_ADDR_WIDTH-1:0] CDF_ADDR,
    input  logic [RANGE_WIDTH-1:0]    CDF_DATA,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SYMBOL_WIDTH-1:0]   SYMBOL_OUT,
    output logic [RANGE_WIDTH-1:0]    RNG_OUT,
    output logic [RANGE_WIDTH-1:0]    DIF_OUT,
    output logic [$clog2(RANGE_WIDTH)-1:0] D_OUT
);
    localparam int VW = RANGE_WIDTH + 1;
    localparam int PW = 2 * RANGE_WIDTH - 14;
    localparam int KW = SYMBOL_WIDTH + 1;
    localparam int DW = $clog2(RANGE_WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] SEARCH = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]             state;
    logic [RANGE_WIDTH-1:0] r, c, u;
    logic [KW-1:0]          n, k, idx, n_next;
    logic [PW-1:0]          prod;
    logic [VW-1:0]          v;
    logic                   cont;
    logic [RANGE_WIDTH-1:0] rs, rs_norm, dif_sub;
    logic [DW-1:0]          d;

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    // k runs one ahead of the entry being compared so the next read is already in flight
    assign CDF_ADDR  = (state == SEARCH) ? CDF_ADDR_WIDTH'(k) : '0;

    always_comb begin
        idx     = k - KW'(1);
        prod    = PW'(r >> 8) * PW'(CDF_DATA >> 6);
        v       = VW'(prod >> 1) + VW'({n - idx, 2'b00});
        cont    = ({1'b0, c} < v) && (idx < n);
        rs      = u - v[RANGE_WIDTH-1:0];
        dif_sub = c - v[RANGE_WIDTH-1:0];
        d       = '0;
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (rs[i]) d = DW'(RANGE_WIDTH - 1 - i);
        end
        rs_norm = rs << d;
        if (BOOL)
            n_next = KW'(1);
        else if (NSYMS < KW'(2))
            n_next = KW'(1);
        else
            n_next = NSYMS - KW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            r          <= '0;
            c          <= '0;
            u          <= '0;
            n          <= '0;
            k          <= '0;
            SYMBOL_OUT <= '0;
            RNG_OUT    <= '0;
            DIF_OUT    <= '0;
            D_OUT      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r     <= RNG;
                        c     <= DIF;
                        u     <= RNG;
                        n     <= n_next;
                        k     <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    k     <= KW'(1);
                    state <= SEARCH;
                end
                SEARCH: begin
                    if (cont) begin
                        u <= v[RANGE_WIDTH-1:0];
                        k <= k + KW'(1);
                    end else begin
                        SYMBOL_OUT <= idx[SYMBOL_WIDTH-1:0];
                        RNG_OUT    <= rs_norm;
                        DIF_OUT    <= dif_sub;
                        D_OUT      <= d;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ec_dec_symbol_search.sv
// tb/tb_ec_dec_symbol_search.sv - scoreboard bench for ec_dec_symbol_search
module tb_ec_dec_symbol_search;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, BOOL, out_valid, out_ready;
    logic [15:0] RNG, DIF, CDF_DATA, RNG_OUT, DIF_OUT;
    logic [4:0]  NSYMS;
    logic [3:0]  CDF_ADDR, SYMBOL_OUT, D_OUT;
    logic [15:0] icdf [16];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]  sym;
        logic [15:0] rng;
        logic [15:0] dif;
        logic [3:0]  d;
    } exp_t;

    exp_t sb[$];

    ec_dec_symbol_search dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .RNG(RNG), .DIF(DIF), .NSYMS(NSYMS), .BOOL(BOOL),
        .CDF_ADDR(CDF_ADDR), .CDF_DATA(CDF_DATA),
        .out_valid(out_valid), .out_ready(out_ready),
        .SYMBOL_OUT(SYMBOL_OUT), .RNG_OUT(RNG_OUT), .DIF_OUT(DIF_OUT), .D_OUT(D_OUT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) CDF_DATA <= icdf[CDF_ADDR];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int s, input int r, input int di, input int d);
        exp_t e;
        e.sym = 4'(s);
        e.rng = 16'(r);
        e.dif = 16'(di);
        e.d   = 4'(d);
        return e;
    endfunction

    function automatic exp_t model(input int rng, input int dif, input int nsyms, input bit bl);
        int n, u, v, s, rs, d, ci;
        n = bl ? 1 : (((nsyms < 2) ? 2 : nsyms) - 1);
        u = rng;
        v = 0;
        s = 0;
        for (int i = 0; i <= n; i++) begin
            ci = int'(icdf[i]);
            v  = (((rng >> 8) * (ci >> 6)) >> 1) + 4 * (n - i);
            s  = i;
            if (i == n || dif >= v) break;
            u = v;
        end
        rs = (u - v) & 32'hffff;
        d  = 0;
        while (d < 15 && rs[15-d] == 1'b0) d++;
        return mk(s, (rs << d) & 32'hffff, (dif - v) & 32'hffff, d);
    endfunction

    // Entered and left at a falling edge; holds out_ready low for `stall` cycles of out_valid.
    task automatic run_req(input logic [15:0] rng, input logic [15:0] dif, input logic [4:0] nsyms,
                           input logic bl, input exp_t e, input int stall);
        int   m;
        int   guard;
        exp_t x;
        RNG = rng; DIF = dif; NSYMS = nsyms; BOOL = bl;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb.push_back(e);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        RNG   = 16'($urandom);
        DIF   = 16'($urandom);
        NSYMS = 5'($urandom_range(2, 16));
        BOOL  = 1'($urandom);
        m = 0;
        while (!out_valid && m < 40) begin
            check("cdf_addr", CDF_ADDR, m % 16);
            @(negedge clk);
            m++;
        end
        check("out_valid", out_valid, 1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            x = sb.pop_front();
            check("latency", m, int'(x.sym) + 2);
            check("symbol", SYMBOL_OUT, x.sym);
            check("rng_out", RNG_OUT, x.rng);
            check("dif_out", DIF_OUT, x.dif);
            check("d_out", D_OUT, x.d);
            check("in_ready_busy", in_ready, 0);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
                check("hold_symbol", SYMBOL_OUT, x.sym);
                check("hold_rng", RNG_OUT, x.rng);
                check("hold_dif", DIF_OUT, x.dif);
                check("hold_d", D_OUT, x.d);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_hs", in_ready, 1);
        check("valid_after_hs", out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_symbol"}, SYMBOL_OUT, 0);
        check({tag, "_rng"}, RNG_OUT, 0);
        check({tag, "_dif"}, DIF_OUT, 0);
        check({tag, "_d"}, D_OUT, 0);
        check({tag, "_addr"}, CDF_ADDR, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic load_uniform();
        for (int i = 0; i < 16; i++) icdf[i] = 16'(30720 - 2048 * i);
    endtask

    initial begin
        int   seen;
        int   ns;
        int   cur;
        int   rng_r;
        int   dif_r;
        exp_t e;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        RNG = '0; DIF = '0; NSYMS = 5'd2; BOOL = 1'b0;
        for (int i = 0; i < 16; i++) icdf[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        // boolean decode, both outcomes
        icdf[0] = 16'd16384;
        icdf[1] = 16'd0;
        run_req(16'd32768, 16'd20000, 5'd2, 1'b1, mk(0, 65520, 3612, 2), 0);
        run_req(16'd32768, 16'd100, 5'd2, 1'b1, mk(1, 32776, 100, 1), 0);

        // four-symbol table, plain then with backpressure and a back-to-back follow-up
        icdf[0] = 16'd24576; icdf[1] = 16'd16384; icdf[2] = 16'd8192; icdf[3] = 16'd0;
        run_req(16'd65280, 16'd30000, 5'd4, 1'b0, mk(2, 65296, 13676, 2), 0);
        run_req(16'd65280, 16'd30000, 5'd4, 1'b0, mk(2, 65296, 13676, 2), 5);
        run_req(16'd65280, 16'd30000, 5'd4, 1'b0, mk(2, 65296, 13676, 2), 0);

        // reset during a worst-case search
        load_uniform();
        RNG = 16'd32768; DIF = 16'd0; NSYMS = 5'd16; BOOL = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        @(negedge clk);
        check("midreset_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("midreset_no_valid", seen, 0);

        // maximum-length search
        run_req(16'd32768, 16'd0, 5'd16, 1'b0, mk(15, 32832, 0, 4), 0);

        // random monotone tables against the reference model
        for (int t = 0; t < 8; t++) begin
            ns  = $urandom_range(2, 16);
            cur = 30000;
            for (int i = 0; i < 16; i++) icdf[i] = '0;
            for (int i = 0; i < ns - 1; i++) begin
                cur     = cur - $urandom_range(1, 30000 / ns);
                icdf[i] = 16'(cur);
            end
            rng_r = $urandom_range(32768, 65535);
            dif_r = $urandom_range(0, rng_r - 1);
            e = model(rng_r, dif_r, ns, 1'b0);
            run_req(16'(rng_r), 16'(dif_r), 5'(ns), 1'b0, e, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
